scan_addr_gen: RTL and testbench



---
 rtl/scan_pkg.sv | 14 +
 rtl/term_counter.sv | 20 ++
 rtl/scan_addr_gen.sv | 95 +++++++++
 tb/tb_scan_addr_gen.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// scan_pkg: shared types, counter widths and parameter limits for the scan address generator
package scan_pkg;
   typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;
   localparam int DWELL_W   = 8;
   localparam int BLANK_W   = 4;
   localparam int MIN_SLOTS = 2;
   localparam int MAX_SLOTS = 8;
   localparam int MIN_DWELL = 1;
   localparam int MAX_DWELL = 255;
   localparam int MAX_BLANK = 15;
   function automatic bit params_ok(input int n, input int d, input int b);
      return n >= MIN_SLOTS && n <= MAX_SLOTS && d >= MIN_DWELL && d <= MAX_DWELL && b >= 0 && b <= MAX_BLANK;
   endfunction
endpackage

// File: rtl/term_counter.sv
// term_counter: loadable up-counter that saturates at TERM and flags the terminal count
module term_counter #(
   parameter int W = 8,
   parameter logic [W-1:0] TERM = '1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count,
   output logic         tc
);
   assign tc = count == TERM;
   always_ff @(posedge clk)
      if (rst || clr) count <= '0;
      else if (load) count <= load_val;
      else if (en && !tc) count <= count + 1'b1;
endmodule

// File: rtl/scan_addr_gen.sv
// scan_addr_gen: steps a 3-bit slot address with programmable dwell and blanking gap
module scan_addr_gen
   import scan_pkg::*;
#(
   parameter int NUM_SLOTS = 8,
   parameter int DWELL     = 4,
   parameter int BLANK     = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       start,
   input  logic       cont,
   output logic [2:0] addr,
   output logic       valid,
   output logic       busy,
   output logic       frame_done
);
   localparam logic [2:0]         LAST    = 3'(NUM_SLOTS - 1);
   localparam logic [DWELL_W-1:0] D_TERM  = DWELL_W'(DWELL - 1);
   localparam logic [BLANK_W-1:0] B_TERM  = BLANK_W'(BLANK == 0 ? 0 : BLANK - 1);
   localparam bit                 HAS_GAP = BLANK > 0;
   localparam bit                 ONE_DW  = DWELL == 1;

   generate
      if (!params_ok(NUM_SLOTS, DWELL, BLANK)) begin : g_param_err
         $error("scan_addr_gen: NUM_SLOTS/DWELL/BLANK out of range");
      end
   endgenerate

   state_t             state;
   logic               en_r, valid_r, fd_r, fd_next;
   logic               d_tc, b_tc, last_slot, slot_end, gap_end;
   logic [DWELL_W-1:0] d_cnt;
   logic [BLANK_W-1:0] b_cnt_unused;

   assign last_slot  = addr == LAST;
   assign slot_end   = state == ACTIVE && d_tc;
   assign gap_end    = state == GAP && b_tc;
   assign valid      = valid_r && en_r;
   assign frame_done = fd_r && en_r;

   term_counter #(.W(DWELL_W), .TERM(D_TERM)) u_dwell (
      .clk(clk), .rst(rst), .en(en && state == ACTIVE), .clr(en && slot_end),
      .load(1'b0), .load_val('0), .count(d_cnt), .tc(d_tc)
   );

   term_counter #(.W(BLANK_W), .TERM(B_TERM)) u_blank (
      .clk(clk), .rst(rst), .en(en && state == GAP), .clr(en && gap_end),
      .load(1'b0), .load_val('0), .count(b_cnt_unused), .tc(b_tc)
   );

   // frame_done is registered, so predict the final cycle one edge ahead
   assign fd_next = (state == ACTIVE && !d_tc && last_slot && d_cnt + 1'b1 == D_TERM)
                 || (ONE_DW && ((gap_end && last_slot) || (slot_end && !HAS_GAP && addr == LAST - 1'b1)));

   always_ff @(posedge clk)
      if (rst) begin
         state   <= IDLE;
         addr    <= '0;
         valid_r <= 1'b0;
         busy    <= 1'b0;
         fd_r    <= 1'b0;
         en_r    <= 1'b0;
      end else begin
         en_r <= en;
         if (en) begin
            fd_r <= fd_next;
            case (state)
               IDLE: if (start) begin
                  state   <= ACTIVE;
                  valid_r <= 1'b1;
                  busy    <= 1'b1;
               end
               ACTIVE: if (d_tc) begin
                  if (last_slot && !cont) begin
                     state   <= IDLE;
                     addr    <= '0;
                     valid_r <= 1'b0;
                     busy    <= 1'b0;
                  end else begin
                     addr    <= last_slot ? 3'd0 : addr + 1'b1;
                     state   <= HAS_GAP ? GAP : ACTIVE;
                     valid_r <= !HAS_GAP;
                  end
               end
               GAP: if (b_tc) begin
                  state   <= ACTIVE;
                  valid_r <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
endmodule

// File: tb/tb_scan_addr_gen.sv
// tb_scan_addr_gen: directed checks of three scan_addr_gen configurations against a closed-form frame model
module tb_scan_addr_gen;
   logic       clk = 1'b0;
   logic       rst, en, start, cont;
   logic [2:0] addr0, addr1, addr2, prev2;
   logic       valid0, valid1, valid2, busy0, busy1, busy2, fd0, fd1, fd2;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   scan_addr_gen #(.NUM_SLOTS(8), .DWELL(4), .BLANK(1)) dut0 (
      .clk(clk), .rst(rst), .en(en), .start(start), .cont(cont),
      .addr(addr0), .valid(valid0), .busy(busy0), .frame_done(fd0));
   scan_addr_gen #(.NUM_SLOTS(4), .DWELL(1), .BLANK(0)) dut1 (
      .clk(clk), .rst(rst), .en(en), .start(start), .cont(cont),
      .addr(addr1), .valid(valid1), .busy(busy1), .frame_done(fd1));
   scan_addr_gen #(.NUM_SLOTS(8), .DWELL(4), .BLANK(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .start(start), .cont(cont),
      .addr(addr2), .valid(valid2), .busy(busy2), .frame_done(fd2));

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // expected {busy, frame_done, valid, addr} for cycle c of an f-frame run (cycle 1 = first slot)
   function automatic logic [5:0] model(input int c, input int n, input int d, input int b, input int f);
      int p = n * (d + b);
      int k, slot, ph;
      logic v, fd;
      logic [2:0] a;
      if (c < 1 || c > p * f - b) return 6'b0;
      k    = (c - 1) % p;
      slot = k / (d + b);
      ph   = k % (d + b);
      v    = ph < d;
      a    = v ? 3'(slot) : 3'((slot + 1) % n);
      fd   = slot == n - 1 && ph == d - 1;
      return {1'b1, fd, v, a};
   endfunction

   task automatic cmp(input string tag, input int c, input logic [5:0] got, input logic [5:0] exp);
      check($sformatf("%s c%0d addr", tag, c), 8'(got[2:0]), 8'(exp[2:0]));
      check($sformatf("%s c%0d valid", tag, c), 8'(got[3]), 8'(exp[3]));
      check($sformatf("%s c%0d frame_done", tag, c), 8'(got[4]), 8'(exp[4]));
      check($sformatf("%s c%0d busy", tag, c), 8'(got[5]), 8'(exp[5]));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en = 1'b1;
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic start_frame();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // addr must only move while valid is low
   always @(negedge clk) begin
      if (valid2 === 1'b1) check("glitch d2 addr", 8'(addr2), 8'(prev2));
      prev2 = addr2;
   end

   initial begin
      prev2 = '0;
      rst = 1'b1;
      en = 1'b1;
      start = 1'b0;
      cont = 1'b0;
      repeat (2) @(negedge clk);
      cmp("reset d0", 0, {busy0, fd0, valid0, addr0}, 6'b0);
      cmp("reset d2", 0, {busy2, fd2, valid2, addr2}, 6'b0);

      do_reset();
      cont = 1'b0;
      start_frame();
      for (int c = 1; c <= 48; c++) begin
         cmp("single d0", c, {busy0, fd0, valid0, addr0}, model(c, 8, 4, 1, 1));
         cmp("single d1", c, {busy1, fd1, valid1, addr1}, model(c, 4, 1, 0, 1));
         cmp("single d2", c, {busy2, fd2, valid2, addr2}, model(c, 8, 4, 2, 1));
         @(negedge clk);
      end

      do_reset();
      cont = 1'b1;
      start_frame();
      for (int c = 1; c <= 12; c++) begin
         cmp("cont d1", c, {busy1, fd1, valid1, addr1}, model(c, 4, 1, 0, 100));
         cmp("cont d0", c, {busy0, fd0, valid0, addr0}, model(c, 8, 4, 1, 100));
         @(negedge clk);
      end

      do_reset();
      cont = 1'b0;
      start_frame();
      for (int c = 1; c <= 45; c++) begin
         cmp("pause d0", c, {busy0, fd0, valid0, addr0},
             c <= 11 ? model(c, 8, 4, 1, 1) : c <= 14 ? 6'b100_010 : model(c - 3, 8, 4, 1, 1));
         en = !(c >= 11 && c <= 13);
         @(negedge clk);
      end
      en = 1'b1;

      do_reset();
      start_frame();
      for (int c = 1; c <= 27; c++) begin
         cmp("prereset d0", c, {busy0, fd0, valid0, addr0}, model(c, 8, 4, 1, 1));
         if (c < 27) @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      cmp("midreset d0", 28, {busy0, fd0, valid0, addr0}, 6'b0);
      rst = 1'b0;
      @(negedge clk);

      do_reset();
      cont = 1'b1;
      start_frame();
      for (int c = 1; c <= 84; c++) begin
         cmp("busystart d0", c, {busy0, fd0, valid0, addr0}, model(c, 8, 4, 1, 2));
         cmp("busystart d1", c, {busy1, fd1, valid1, addr1}, model(c, 4, 1, 0, 19));
         cmp("busystart d2", c, {busy2, fd2, valid2, addr2}, model(c, 8, 4, 2, 2));
         start = c == 20;
         if (c == 76) cont = 1'b0;
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
